// File: rtl/sha256_block_core_if.sv
// Block-level bus for sha256_block_core: message block, start request, digest and done flag.
// SHA256_CHAIN_EN adds the chain/h_in inputs used to continue a multi-block message.
interface sha256_block_core_if;
  logic [511:0] in;
  logic         start;
  logic         done;
  logic [255:0] out;
`ifdef SHA256_CHAIN_EN
  logic         chain;
  logic [255:0] h_in;

  modport master (output in, output start, output chain, output h_in, input done, input out);
  modport slave  (input in, input start, input chain, input h_in, output done, output out);
`else
  modport master (output in, output start, input done, input out);
  modport slave  (input in, input start, output done, output out);
`endif
endinterface

// File: rtl/sha256_block_core.sv
// Iterative SHA-256 compression: one round per clock, 16-word sliding schedule window.
// Define SHA256_CHAIN_EN to seed a..h and the feed-forward value from h_in when chain=1.
module sha256_block_core (
  input  logic         clk,
  input  logic         reset_n,
  sha256_block_core_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  logic [1:0]   state_q, state_d;
  logic [5:0]   round_q, round_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [255:0] wv_q, wv_d;     // working variables a..h, a in the top word
  logic [255:0] hv_q, hv_d;     // feed-forward base captured at acceptance
  logic [255:0] out_q, out_d;
  logic         done_q, done_d;

  logic [31:0]  in_w [16];
  logic [255:0] digest;
  logic [255:0] init_h;

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_in_words
    assign in_w[gi] = bus.in[511 - 32*gi -: 32];
  end

  for (gi = 0; gi < 8; gi++) begin : g_feed_fwd
    assign digest[255 - 32*gi -: 32] = hv_q[255 - 32*gi -: 32] + wv_q[255 - 32*gi -: 32];
  end

`ifdef SHA256_CHAIN_EN
  assign init_h = bus.chain ? bus.h_in : IV;
`else
  assign init_h = IV;
`endif

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2, w_new;

  assign {a, b, c, d, e, f, g, h} = wv_q;
  assign t1    = h + big_sig1(e) + ((e & f) ^ (~e & g)) + K[round_q] + w_q[0];
  assign t2    = big_sig0(a) + ((a & b) ^ (a & c) ^ (b & c));
  // w_q[0] is W[t]; the window always holds W[t..t+15], so this yields W[t+16].
  assign w_new = small_sig1(w_q[14]) + w_q[9] + small_sig0(w_q[1]) + w_q[0];

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    w_d     = w_q;
    wv_d    = wv_q;
    hv_d    = hv_q;
    out_d   = out_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          w_d     = in_w;
          wv_d    = init_h;
          hv_d    = init_h;
          round_d = 6'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        wv_d = {t1 + t2, a, b, c, d + t1, e, f, g};
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
        w_d[15] = w_new;
        round_d = round_q + 6'd1;
        if (round_q == 6'd63) state_d = S_DONE;
      end
      S_DONE: begin
        // First DONE cycle finalizes; start is only honoured once the digest is visible.
        if (!done_q) begin
          out_d  = digest;
          done_d = 1'b1;
        end else if (bus.start) begin
          w_d     = in_w;
          wv_d    = init_h;
          hv_d    = init_h;
          round_d = 6'd0;
          done_d  = 1'b0;
          state_d = S_ROUND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      round_q <= 6'd0;
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
      wv_q    <= 256'd0;
      hv_q    <= 256'd0;
      out_q   <= 256'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      w_q     <= w_d;
      wv_q    <= wv_d;
      hv_q    <= hv_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule

// File: tb/tb_sha256_block_core.sv
// Self-checking bench for sha256_block_core: known-answer vectors, random blocks against a
// whole-message-schedule reference model, reset abort, start toggling and back-to-back runs.
module tb_sha256_block_core;

  logic clk;
  logic reset_n;
  sha256_block_core_if bus();

  sha256_block_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] k_ref [64];

  localparam logic [255:0] IV_REF =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO_BLOCK =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // Round constants derived from the cube roots of the first 64 primes.
  function automatic void init_k();
    int n;
    int p;
    bit is_prime;
    real x;
    n = 0;
    p = 2;
    while (n < 64) begin
      is_prime = 1'b1;
      for (int dv = 2; dv * dv <= p; dv++) if (p % dv == 0) is_prime = 1'b0;
      if (is_prime) begin
        x = real'(p) ** (1.0 / 3.0);
        x = x - (x * x * x - real'(p)) / (3.0 * x * x);
        k_ref[n] = 32'(longint'($floor((x - $floor(x)) * 4294967296.0)));
        n++;
      end
      p++;
    end
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] h_init, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hh [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) begin
      hh[i] = h_init[255 - 32*i -: 32];
      v[i]  = hh[i];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_ref[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hh[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept blk, scramble the input afterwards, and check the 65-edge latency and digest.
  task automatic run_hash(input string tag, input logic [511:0] blk, input logic [255:0] exp);
    bus.in    = blk;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.in    = rand_block();
    repeat (64) step();
    chk1({tag, " done low at edge 64"}, bus.done, 1'b0);
    step();
    chk1({tag, " done at edge 65"}, bus.done, 1'b1);
    chk256({tag, " digest"}, bus.out, exp);
    $display("txn %s: digest %h", tag, bus.out);
  endtask

  logic [511:0] blk_abc, blk_empty, blk_rand, blk_c1, blk_c2;
  logic [255:0] exp_rand;
  logic [23:0]  msg_abc;
  logic [447:0] msg_56;
  int rises, low_cnt;
  logic prev_done;

  initial begin
    init_k();
    msg_abc   = "abc";
    msg_56    = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    blk_abc   = {msg_abc, 8'h80, 416'd0, 64'd24};
    blk_empty = {8'h80, 440'd0, 64'd0};
    blk_c1    = {msg_56, 8'h80, 56'd0};
    blk_c2    = {448'd0, 64'd448};

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.in    = '0;
`ifdef SHA256_CHAIN_EN
    bus.chain = 1'b0;
    bus.h_in  = '0;
`endif
    #1;
    chk1("reset done", bus.done, 1'b0);
    chk256("reset out", bus.out, 256'd0);
    // Inputs are ignored while held in reset.
    bus.start = 1'b1;
    bus.in    = blk_abc;
    repeat (3) step();
    chk1("start during reset", bus.done, 1'b0);
    bus.start = 1'b0;
    #2 reset_n = 1'b1;

    run_hash("abc", blk_abc, DIG_ABC);

    for (int i = 0; i < 20; i++) begin
      bus.in = rand_block();
      step();
    end
    chk1("hold done", bus.done, 1'b1);
    chk256("hold out", bus.out, DIG_ABC);

    run_hash("empty", blk_empty, DIG_EMPTY);

    for (int r = 0; r < 4; r++) begin
      blk_rand = rand_block();
      exp_rand = ref_compress(IV_REF, blk_rand);
      run_hash($sformatf("rand%0d", r), blk_rand, exp_rand);
    end

    // Asynchronous reset at round 30 of a hash.
    bus.in    = blk_abc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (30) step();
    #2 reset_n = 1'b0;
    #1;
    chk1("async reset done", bus.done, 1'b0);
    chk256("async reset out", bus.out, 256'd0);
    bus.start = 1'b1;
    repeat (2) step();
    bus.start = 1'b0;
    #2 reset_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (bus.done) rises++;
    end
    chk_int("no done after abort", rises, 0);
    chk256("out clear after abort", bus.out, 256'd0);
    $display("txn reset-abort: done cycles %0d", rises);
    run_hash("abc after reset", blk_abc, DIG_ABC);

    // start toggled and in changed during ROUND.
    blk_rand  = rand_block();
    exp_rand  = ref_compress(IV_REF, blk_rand);
    bus.in    = blk_rand;
    bus.start = 1'b1;
    step();
    prev_done = bus.done;
    rises     = 0;
    for (int i = 1; i <= 70; i++) begin
      bus.start = (i <= 64) ? (i % 2 == 1) : 1'b0;
      bus.in    = rand_block();
      step();
      if (bus.done && !prev_done) rises++;
      prev_done = bus.done;
      if (i == 65) chk1("toggle done at edge 65", bus.done, 1'b1);
    end
    chk_int("toggle done rises", rises, 1);
    chk256("toggle digest", bus.out, exp_rand);
    $display("txn toggle: rises %0d digest %h", rises, bus.out);

    // start held high: abc then empty back to back.
    bus.in    = blk_abc;
    bus.start = 1'b1;
    step();
    bus.in = blk_empty;
    repeat (64) step();
    chk1("b2b first not early", bus.done, 1'b0);
    step();
    chk1("b2b first done", bus.done, 1'b1);
    chk256("b2b first digest", bus.out, DIG_ABC);
    step();
    chk1("b2b done falls on accept", bus.done, 1'b0);
    chk256("b2b out keeps old", bus.out, DIG_ABC);
    low_cnt = 1;
    for (int i = 0; i < 100 && !bus.done; i++) begin
      step();
      if (!bus.done) low_cnt++;
    end
    bus.start = 1'b0;
    chk_int("b2b done low edges", low_cnt, 65);
    chk1("b2b second done", bus.done, 1'b1);
    chk256("b2b second digest", bus.out, DIG_EMPTY);
    $display("txn back-to-back: low %0d digest %h", low_cnt, bus.out);
    step();

`ifdef SHA256_CHAIN_EN
    bus.chain = 1'b0;
    run_hash("chain blk1", blk_c1, ref_compress(IV_REF, blk_c1));
    bus.chain = 1'b1;
    bus.h_in  = ref_compress(IV_REF, blk_c1);
    run_hash("chain blk2", blk_c2, DIG_TWO_BLOCK);
    bus.chain = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_block_core.md
SHA256_BLOCK_CORE -- requirements
Module: sha256_block_core

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 SHALL have one clock and an asynchronous active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in  input  512  one pre-padded message block, big-endian: in[511:480] is W0, in[31:0] is W15.
REQ-006 start  input  1  request to hash `in`; sampled on clk rising edge.
REQ-007 done  output  1  registered; high while `out` holds a valid digest.
REQ-008 out  output  256  registered digest, big-endian: out[255:224] is H0, out[31:0] is H7.

Function
REQ-009 SHALL compute the FIPS 180-4 SHA-256 compression of `in` from the standard IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), including the feed-forward addition.
- Padding is not performed; `in` is a complete block.
REQ-010 SHALL implement states IDLE, ROUND, DONE.
- IDLE: start=1 -> capture `in` into a 16-word schedule window; load a..h = IV; round counter = 0; go to ROUND.
- ROUND: one round per clock (t = 0..63); after t = 63 go to DONE.
- DONE: `out` = IV + a..h (per-word, mod 2^32); done = 1.
REQ-011 SHALL compute the schedule on the fly in a 16-entry sliding window.
- W[t] for t >= 16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], all mod 2^32.
REQ-012 SHALL use the 64 standard round constants K[0..63] from a combinational table.
REQ-013 Latency: done SHALL rise on the 65th clk rising edge after the edge that accepts start, i.e. 64 round edges plus one finalize edge.
REQ-014 start SHALL be ignored while in ROUND; `in` SHALL be sampled only at the accepting edge and may change afterwards.
REQ-015 In DONE, done and `out` SHALL hold indefinitely while start = 0.
REQ-016 In DONE, start = 1 SHALL start a new block on that edge; done SHALL fall at that same edge; `out` SHALL keep the old digest until the new one is written.
REQ-017 start held high continuously SHALL produce back-to-back hashes, one new acceptance per DONE visit.
REQ-018 All arithmetic SHALL be modulo 2^32; Ch, Maj, Σ0, Σ1, σ0, σ1 as in FIPS 180-4.

Reset
REQ-019 reset_n low SHALL immediately clear state to IDLE, done = 0, out = 0, round counter = 0, independent of clk.
REQ-020 Reset mid-hash SHALL abort the operation with no partial digest; after release, a fresh start is required.
REQ-021 Inputs SHALL be ignored while reset_n = 0; the first acceptance is possible on the first rising edge after release.

Configuration
REQ-022 Macro SHA256_CHAIN_EN SHALL control multi-block chaining.
- Defined: adds inputs `chain` (1 bit) and `h_in` (256 bits). If chain = 1 at acceptance, a..h and the feed-forward value SHALL be loaded from h_in instead of the IV.
- Undefined: these ports do not exist and the IV is always used.

Verification
REQ-023 Block "abc" (616263 80 00.. length 0x18) with start pulsed for 1 cycle -> done rises 65 edges later; out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-024 Empty-message block (80 00.. length 0) -> out = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-025 reset_n pulsed low at round 30 of a hash -> done = 0 and out = 0 immediately; no done until a new start; the next "abc" hash completes correctly.
REQ-026 start toggled every cycle during ROUND and `in` changed mid-hash -> digest still matches the first-captured block; done rises exactly once.
REQ-027 start held high across two completions ("abc" then empty) -> done falls for 65 cycles between results; both digests correct.
REQ-028 With SHA256_CHAIN_EN: block 1 of the 56-byte message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", then block 2 with chain = 1 and h_in = the first digest -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
